// File: rtl/wb_pipe_mem.sv
// ---------------------------------------------------------------------------
// wb_pipe_mem : pipelined Wishbone B4 slave memory model
//
// Accepts one request per cycle when not stalled, commits writes / captures
// reads at the accept edge, and returns responses in order through a small
// response FIFO that holds each entry for at least RESP_DELAY edges.
// Stall injection (LFSR or periodic) is deterministic from reset.
//
// Ports:
//   clk      in   1         clock
//   rst      in   1         asynchronous active-high reset
//   addr_i   in   32        byte address (sub-word bits ignored)
//   data_i   in   DATA_W    write data
//   data_o   out  DATA_W    read data, valid with ack_o, zero otherwise
//   sel_i    in   DATA_W/8  byte enables (writes only)
//   cyc_i    in   1         bus cycle; low flushes pending responses
//   stb_i    in   1         request strobe
//   we_i     in   1         write enable
//   stall_o  out  1         request not accepted this cycle
//   ack_o    out  1         successful response
//   err_o    out  1         error response (address out of range)
// ---------------------------------------------------------------------------
module wb_pipe_mem #(
   parameter int          DATA_W          = 32,
   parameter int          MEM_WORDS_W     = 14,
   parameter int          MAX_OUTSTANDING = 4,
   parameter int          RESP_DELAY      = 0,
   parameter int          STALL_MODE      = 1,
   parameter int          STALL_PERIOD    = 8,
   parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           addr_i,
   input  logic [DATA_W-1:0]     data_i,
   output logic [DATA_W-1:0]     data_o,
   input  logic [DATA_W/8-1:0]   sel_i,
   input  logic                  cyc_i,
   input  logic                  stb_i,
   input  logic                  we_i,
   output logic                  stall_o,
   output logic                  ack_o,
   output logic                  err_o
);

   localparam int BYTES = DATA_W / 8;
   localparam int OFF_W = (BYTES > 1) ? $clog2(BYTES) : 0;
   localparam int DEPTH = 2 ** MEM_WORDS_W;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
   localparam logic [4:0]       DELAY    = 5'(RESP_DELAY);
   localparam logic [7:0]       PER_LAST = 8'(STALL_PERIOD - 1);

   // Wrap-around increment that also works for non-binary-aligned limits.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      logic [PTR_W-1:0] r;
      if (p == PTR_LAST) begin
         r = '0;
      end else begin
         r = p + PTR_W'(1);
      end
      return r;
   endfunction

   // Backing store: deliberately not reset.
   logic [DATA_W-1:0] mem [DEPTH];

   // Response FIFO storage.
   logic [DATA_W-1:0] fifo_data [MAX_OUTSTANDING];
   logic              fifo_err  [MAX_OUTSTANDING];
   logic [3:0]        fifo_age  [MAX_OUTSTANDING];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;

   logic [15:0] lfsr;
   logic [7:0]  per_cnt;

   logic [31:0]            word_idx;
   logic [MEM_WORDS_W-1:0] mem_idx;
   logic                   in_range;
   logic [DATA_W-1:0]      push_data;
   logic                   accept;
   logic                   head_ready;
   logic                   pop;
   logic                   push;
   logic                   bypass;
   logic [CNT_W-1:0]       occ_after;
   logic                   full_next;
   logic                   inj_stall;
   logic                   resp_valid;
   logic                   resp_err;
   logic [DATA_W-1:0]      resp_data;
   logic                   ack_reg;
   logic                   err_reg;
   logic [DATA_W-1:0]      data_reg;

   assign word_idx  = addr_i >> OFF_W;
   assign in_range  = ((word_idx >> MEM_WORDS_W) == 32'd0);
   assign mem_idx   = word_idx[MEM_WORDS_W-1:0];
   assign push_data = (in_range && !we_i) ? mem[mem_idx] : {DATA_W{1'b0}};

   assign accept = cyc_i & stb_i & ~stall_o;

   // Stored age counts edges after the push edge, so an entry has spent
   // age+1 edges in flight when the next edge arrives.
   assign head_ready = (count != '0) && ((5'({1'b0, fifo_age[rd_ptr]}) + 5'd1) >= DELAY);
   assign pop        = head_ready & cyc_i;
   // With zero delay an empty FIFO lets the new request answer on its own
   // accept edge instead of being queued.
   assign bypass     = (RESP_DELAY == 0) && accept && (count == '0);
   assign push       = accept & ~bypass;

   // Fullness looks past this edge's pop so a full FIFO can push and pop
   // together; built only from state so stall_o never depends on stb_i.
   assign occ_after = count - CNT_W'(head_ready);
   assign full_next = (occ_after == MAX_CNT);

   // Injected stall source selection.
   always_comb begin
      inj_stall = 1'b0;
      case (STALL_MODE)
         0:       inj_stall = 1'b0;
         1:       inj_stall = (lfsr[2:0] == 3'd0);
         2:       inj_stall = (per_cnt == PER_LAST);
         default: inj_stall = 1'b0;
      endcase
   end

   assign stall_o = full_next | inj_stall;

   // Response selection: FIFO head first, otherwise a zero-delay bypass.
   always_comb begin
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_data  = {DATA_W{1'b0}};
      if (pop) begin
         resp_valid = 1'b1;
         resp_err   = fifo_err[rd_ptr];
         resp_data  = fifo_data[rd_ptr];
      end else if (bypass) begin
         resp_valid = 1'b1;
         resp_err   = ~in_range;
         resp_data  = push_data;
      end else begin
         resp_valid = 1'b0;
      end
   end

   // Byte-masked write commit at the accept edge.
   always_ff @(posedge clk) begin
      if (accept && we_i && in_range) begin
         for (int b = 0; b < BYTES; b++) begin
            if (sel_i[b]) begin
               mem[mem_idx][b*8 +: 8] <= data_i[b*8 +: 8];
            end
         end
      end
   end

   // FIFO payload storage (no reset needed, guarded by count).
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= push_data;
         fifo_err[wr_ptr]  <= ~in_range;
      end
   end

   // FIFO pointers, occupancy and per-entry saturating ages.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            fifo_age[i] <= 4'd0;
         end
      end else begin
         if (!cyc_i) begin
            // Abort: pending responses are dropped; memory keeps its writes.
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (pop) begin
               rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push) begin
               wr_ptr <= ptr_inc(wr_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (push && (PTR_W'(i) == wr_ptr)) begin
               fifo_age[i] <= 4'd0;
            end else if (fifo_age[i] != 4'd15) begin
               fifo_age[i] <= fifo_age[i] + 4'd1;
            end
         end
      end
   end

   // Stall generators: Fibonacci LFSR (taps 16,14,13,11) and period counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr    <= LFSR_SEED;
         per_cnt <= 8'd0;
      end else begin
         lfsr    <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
         per_cnt <= (per_cnt == PER_LAST) ? 8'd0 : per_cnt + 8'd1;
      end
   end

   // Registered response outputs; data is forced to zero without an ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_reg  <= 1'b0;
         err_reg  <= 1'b0;
         data_reg <= {DATA_W{1'b0}};
      end else begin
         ack_reg  <= resp_valid & ~resp_err;
         err_reg  <= resp_valid & resp_err;
         data_reg <= (resp_valid && !resp_err) ? resp_data : {DATA_W{1'b0}};
      end
   end

   assign ack_o  = ack_reg;
   assign err_o  = err_reg;
   assign data_o = data_reg;

endmodule

// File: tb/tb_wb_pipe_mem.sv
module tb_wb_pipe_mem;

   localparam int DA = 0;
   localparam int DB = 6;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst;

   logic [31:0] addr_a, wdat_a, rdat_a, addr_b, wdat_b, rdat_b;
   logic [3:0]  sel_a, sel_b;
   logic        cyc_a, stb_a, we_a, stall_a, ack_a, err_a;
   logic        cyc_b, stb_b, we_b, stall_b, ack_b, err_b;
   logic [31:0] tie32 = 32'd0;
   logic [3:0]  tie4  = 4'd0;
   logic        tie1  = 1'b0;
   logic [31:0] rdat_c, rdat_d;
   logic        stall_c, ack_c, err_c, stall_d, ack_d, err_d;

   wb_pipe_mem #(.RESP_DELAY(DA), .MAX_OUTSTANDING(4), .STALL_MODE(0)) dut_a (
      .clk(clk), .rst(rst), .addr_i(addr_a), .data_i(wdat_a), .data_o(rdat_a),
      .sel_i(sel_a), .cyc_i(cyc_a), .stb_i(stb_a), .we_i(we_a),
      .stall_o(stall_a), .ack_o(ack_a), .err_o(err_a));

   wb_pipe_mem #(.RESP_DELAY(DB), .MAX_OUTSTANDING(4), .STALL_MODE(0)) dut_b (
      .clk(clk), .rst(rst), .addr_i(addr_b), .data_i(wdat_b), .data_o(rdat_b),
      .sel_i(sel_b), .cyc_i(cyc_b), .stb_i(stb_b), .we_i(we_b),
      .stall_o(stall_b), .ack_o(ack_b), .err_o(err_b));

   wb_pipe_mem #(.MEM_WORDS_W(4), .STALL_MODE(2), .STALL_PERIOD(4)) dut_c (
      .clk(clk), .rst(rst), .addr_i(tie32), .data_i(tie32), .data_o(rdat_c),
      .sel_i(tie4), .cyc_i(tie1), .stb_i(tie1), .we_i(tie1),
      .stall_o(stall_c), .ack_o(ack_c), .err_o(err_c));

   wb_pipe_mem #(.MEM_WORDS_W(4), .STALL_MODE(1), .LFSR_SEED(16'hACE1)) dut_d (
      .clk(clk), .rst(rst), .addr_i(tie32), .data_i(tie32), .data_o(rdat_d),
      .sel_i(tie4), .cyc_i(tie1), .stb_i(tie1), .we_i(tie1),
      .stall_o(stall_d), .ack_o(ack_d), .err_o(err_d));

   typedef struct {
      logic        err;
      logic        rd;
      logic [31:0] data;
      int          edge_at;
   } exp_t;

   exp_t        qa[$];
   exp_t        qb[$];
   bit   [31:0] mem_a[int];
   bit   [31:0] mem_b[int];
   int          last_a = -1;
   int          last_b = -1;
   int          resp_a = 0;
   int          resp_b = 0;
   int          tests  = 0;
   int          fails  = 0;
   int          edge_n = 0;
   bit          trace[20];

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic mon(input int which, input logic ack, input logic err, input logic [31:0] d);
      exp_t  e;
      int    sz;
      string p;
      p  = (which == 0) ? "a" : "b";
      sz = (which == 0) ? qa.size() : qb.size();
      if (ack || err) begin
         if (which == 0) resp_a++; else resp_b++;
         check({p, "_resp_expected"}, 32'(sz != 0), 32'd1);
         if (sz != 0) begin
            if (which == 0) e = qa.pop_front(); else e = qb.pop_front();
            check({p, "_ack"}, 32'(ack), 32'(!e.err));
            check({p, "_err"}, 32'(err), 32'(e.err));
            check({p, "_resp_edge"}, 32'(edge_n), 32'(e.edge_at));
            if (e.rd || e.err) check({p, "_data"}, d, e.data);
         end
      end else begin
         check({p, "_idle_data"}, d, 32'd0);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         mon(0, ack_a, err_a, rdat_a);
         mon(1, ack_b, err_b, rdat_b);
      end
   end

   function automatic logic cur_stall(input int which);
      return (which == 0) ? stall_a : stall_b;
   endfunction

   function automatic bit [31:0] mread(input int which, input int idx);
      if (which == 0) return mem_a.exists(idx) ? mem_a[idx] : 32'd0;
      return mem_b.exists(idx) ? mem_b[idx] : 32'd0;
   endfunction

   // Issue one request (called at a negedge), wait for acceptance, record expectation.
   task automatic req(input int which, input logic we, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] sel);
      exp_t        e;
      int          n, idx, acc;
      logic        st;
      bit   [31:0] cur;
      if (which == 0) begin
         cyc_a = 1'b1; stb_a = 1'b1; we_a = we; addr_a = addr; wdat_a = data; sel_a = sel;
      end else begin
         cyc_b = 1'b1; stb_b = 1'b1; we_b = we; addr_b = addr; wdat_b = data; sel_b = sel;
      end
      n  = 0;
      st = cur_stall(which);
      while (st && n < 50) begin
         @(negedge clk);
         n++;
         st = cur_stall(which);
      end
      check("accept_wait", 32'(st), 32'd0);
      idx    = int'(addr >> 2);
      e.err  = !(idx < (2 ** 14));
      e.rd   = !we;
      e.data = 32'd0;
      if (!e.err) begin
         cur = mread(which, idx);
         if (we) begin
            for (int b = 0; b < 4; b++) if (sel[b]) cur[b*8 +: 8] = data[b*8 +: 8];
            if (which == 0) mem_a[idx] = cur; else mem_b[idx] = cur;
         end else begin
            e.data = cur;
         end
      end
      acc = edge_n + 1;
      if (which == 0) begin
         e.edge_at = (acc + DA > last_a) ? acc + DA : last_a + 1;
         last_a    = e.edge_at;
         qa.push_back(e);
      end else begin
         e.edge_at = (acc + DB > last_b) ? acc + DB : last_b + 1;
         last_b    = e.edge_at;
         qb.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input int which);
      int n = 0;
      if (which == 0) stb_a = 1'b0; else stb_b = 1'b0;
      while (((which == 0) ? qa.size() : qb.size()) != 0 && n < 60) begin
         @(negedge clk);
         n++;
      end
      check("drain", 32'((which == 0) ? qa.size() : qb.size()), 32'd0);
   endtask

   // Stall traces for the periodic and LFSR instances; run 0 records, run 1 replays.
   task automatic stall_traces(input int run);
      logic [15:0] l = 16'hACE1;
      for (int k = 0; k < 20; k++) begin
         if (k > 0) begin
            @(negedge clk);
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
         end
         check("periodic_stall", 32'(stall_c), 32'((k % 4) == 3));
         check("lfsr_stall", 32'(stall_d), 32'(l[2:0] == 3'd0));
         if (run == 0) trace[k] = stall_d;
         else check("lfsr_repeat", 32'(stall_d), 32'(trace[k]));
      end
   endtask

   initial begin
      int base;
      rst = 1'b1;
      cyc_a = 1'b0; stb_a = 1'b0; we_a = 1'b0; addr_a = 32'd0; wdat_a = 32'd0; sel_a = 4'd0;
      cyc_b = 1'b0; stb_b = 1'b0; we_b = 1'b0; addr_b = 32'd0; wdat_b = 32'd0; sel_b = 4'd0;
      repeat (3) @(negedge clk);
      check("rst_ack_a", 32'(ack_a), 32'd0);
      check("rst_err_a", 32'(err_a), 32'd0);
      check("rst_data_a", rdat_a, 32'd0);
      check("rst_stall_a", 32'(stall_a), 32'd0);
      check("rst_ack_b", 32'(ack_b), 32'd0);
      check("rst_data_b", rdat_b, 32'd0);
      rst = 1'b0;
      stall_traces(0);
      cyc_a = 1'b1;
      cyc_b = 1'b1;
      @(negedge clk);

      // Single write then read, back to back, zero delay.
      req(0, 1'b1, 32'h100, 32'hDEADBEEF, 4'hF);
      req(0, 1'b0, 32'h100, 32'd0, 4'h0);
      drain(0);
      // Byte enables.
      req(0, 1'b1, 32'h200, 32'h11223344, 4'hF);
      req(0, 1'b1, 32'h200, 32'hAABBCCDD, 4'b0101);
      req(0, 1'b0, 32'h200, 32'd0, 4'h0);
      drain(0);
      // Out-of-range, then in-range reads, including the last word.
      req(0, 1'b0, 32'h0001_0000, 32'd0, 4'h0);
      req(0, 1'b0, 32'h100, 32'd0, 4'h0);
      req(0, 1'b1, 32'h0001_0004, 32'h12345678, 4'hF);
      req(0, 1'b0, 32'h0000_FFFC, 32'd0, 4'h0);
      drain(0);

      // Back-pressure with delay 6 and four outstanding slots.
      for (int i = 0; i < 8; i++) req(1, 1'b1, 32'h40 + 32'(4 * i), 32'hC0DE0000 + 32'(i), 4'hF);
      drain(1);
      for (int i = 0; i < 8; i++) begin
         req(1, 1'b0, 32'h40 + 32'(4 * i), 32'd0, 4'h0);
         if (i == 2) check("b_stall_after_3", 32'(stall_b), 32'd0);
         if (i == 3) check("b_stall_after_4", 32'(stall_b), 32'd1);
      end
      drain(1);

      // Abort: three writes pending, cyc dropped for one cycle.
      req(1, 1'b1, 32'h300, 32'h1, 4'hF);
      req(1, 1'b1, 32'h300, 32'h2, 4'hF);
      req(1, 1'b1, 32'h300, 32'h3, 4'hF);
      cyc_b = 1'b0;
      stb_b = 1'b0;
      qb.delete();
      last_b = -1;
      base = resp_b;
      @(negedge clk);
      cyc_b = 1'b1;
      repeat (12) @(negedge clk);
      check("abort_no_resp", 32'(resp_b), 32'(base));
      req(1, 1'b0, 32'h300, 32'd0, 4'h0);
      drain(1);

      // Reset mid-transaction, then second stall trace run.
      req(1, 1'b0, 32'h40, 32'd0, 4'h0);
      req(1, 1'b0, 32'h44, 32'd0, 4'h0);
      stb_b = 1'b0;
      rst = 1'b1;
      qb.delete();
      last_b = -1;
      base = resp_b;
      repeat (2) @(negedge clk);
      check("rst2_ack_b", 32'(ack_b), 32'd0);
      rst = 1'b0;
      stall_traces(1);
      check("rst_mid_no_resp", 32'(resp_b), 32'(base));
      check("qa_empty_end", 32'(qa.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_pipe_mem.md
# wb_pipe_mem

Parametrised pipelined Wishbone B4 slave memory model for the CPU testbenches. It generalises the fixed random-stall slave in four ways:
- configurable data width, depth and outstanding-request count;
- fixed minimum response latency;
- deterministic, seedable stall injection;
- bus-error responses for out-of-range addresses.

It sits between the core's data/instruction port and the bench's memory image, so runs are reproducible from a single seed.

## Interface
Parameters:
- DATA_W, 32, data width in bits; multiple of 8, max 64
- MEM_WORDS_W, 14, log2 of memory depth in words
- MAX_OUTSTANDING, 4, response FIFO depth; power of 2, 1..16
- RESP_DELAY, 0, minimum cycles from accept edge to ack edge; 0..15
- STALL_MODE, 1
  - 0: no injected stall
  - 1: LFSR stall
  - 2: periodic stall
- STALL_PERIOD, 8, mode 2: stall asserted 1 cycle in every STALL_PERIOD; 2..255
- LFSR_SEED, 16'hACE1, non-zero LFSR reset value

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- addr_i  in  32  byte address; bits below log2(DATA_W/8) ignored
- data_i  in  DATA_W  write data
- data_o  out  DATA_W  read data, valid with ack_o
- sel_i  in  DATA_W/8  byte enables
- cyc_i  in  1  bus cycle
- stb_i  in  1  request strobe
- we_i  in  1  write enable
- stall_o  out  1  request not accepted this cycle
- ack_o  out  1  successful response
- err_o  out  1  error response (address out of range)

## Operation
- **Accept:** a request is accepted on a rising edge when cyc_i & stb_i & !stall_o.
- **Address range:** word index = addr_i >> log2(DATA_W/8). The address is in range if word index < 2^MEM_WORDS_W.
- **Writes** commit to memory at the accept edge, per byte, only where sel_i is set.
- **Reads** capture the memory word at the accept edge, full word, regardless of sel_i.
  - A read accepted after a write (even on the next edge) returns the written data.
- **Out-of-range:** no memory access. The response is err_o instead of ack_o; data_o is 0.
- **Response FIFO:** each accepted request pushes {data, is_err, age=0}. Age increments each cycle and saturates at 15.
- **Pop:** the head entry pops when age ≥ RESP_DELAY. At most one response per cycle, strictly in acceptance order.
- **stall_o** = fifo_full_next | injected_stall.
  - fifo_full_next: occupancy after this edge's pop would equal MAX_OUTSTANDING.
- **Injected stall**, one of three modes:
  - Mode 0: never.
  - Mode 1: 16-bit Fibonacci LFSR, taps 16,14,13,11, shifts every cycle; stall when lfsr[2:0] == 0 (≈1/8 duty).
  - Mode 2: free-running counter 0..STALL_PERIOD-1; stall when it equals STALL_PERIOD-1.
- **Abort:** cyc_i low flushes the FIFO at the next edge.
  - Pending responses are discarded: no ack/err for them.
  - Committed writes remain in memory.
  - While cyc_i is low, no responses are issued.
- **Memory contents** are not reset; the simulation initial value is all zeros.

## Timing
- **Reset values:** ack_o=0, err_o=0, data_o=0, FIFO empty, LFSR=LFSR_SEED, period counter=0.
  - stall_o after reset reflects only injected stall (mode 1: seed 16'hACE1 ⇒ lfsr[2:0]=1 ⇒ 0).
- ack_o, err_o and data_o are registered; data_o = 0 whenever ack_o = 0.
- **Latency:** request accepted at edge T ⇒ ack/err registered at edge T+RESP_DELAY at the earliest, visible in the following cycle.
  - RESP_DELAY=0 gives a response in the cycle immediately after acceptance.
- **Throughput:** one accept and one response per cycle sustained when there is no injected stall and MAX_OUTSTANDING ≥ RESP_DELAY+1.
- **Simultaneous push and pop** at a full FIFO is legal only because fullness is evaluated on fifo_full_next. Pop frees the slot in the same edge.
- **stall_o** is combinational from state only (registered counters and LFSR), never from stb_i.
- **Reset mid-transaction:** all pending responses are lost; no ack/err is issued after rst deasserts until a new accept.

## Test plan
- **Single write then read:** RESP_DELAY=0, STALL_MODE=0. Write 0xDEADBEEF to 0x100 with sel=4'hF, then read 0x100 next cycle ⇒ two acks on consecutive cycles; read data_o=0xDEADBEEF.
- **Byte enables:** write 0x11223344 (sel=F), then 0xAABBCCDD with sel=4'b0101, read ⇒ 0x11BB33DD.
- **Back-pressure:** RESP_DELAY=6, MAX_OUTSTANDING=4. Issue 8 back-to-back reads.
  - stall_o rises after the 4th accept.
  - First ack arrives 7 cycles after the first accept.
  - All 8 acks arrive in order.
- **Out-of-range:** MEM_WORDS_W=14. Read 0x0001_0000 ⇒ err_o=1, ack_o=0, data_o=0. The next in-range read acks normally.
- **Abort:** RESP_DELAY=4. Three writes accepted, then cyc_i dropped for 1 cycle ⇒ no ack/err issued. A subsequent read returns the 3rd write's data.
- **Stall determinism:**
  - STALL_MODE=2, STALL_PERIOD=4 ⇒ stall_o high exactly cycles 3, 7, 11, … after reset.
  - STALL_MODE=1 with the same seed ⇒ identical stall_o trace across two runs.
